// File: rtl/pal_line_scheduler_if.sv
// VDG-side signals for the PAL padding-line scheduler.
// master: the VDG/timing source side that drives sync and format.
// slave: the scheduler, which returns the hold/pad strobes and line count.
interface pal_line_scheduler_if;
  logic       HSn;
  logic       FSn;
  logic       Format;
  logic       Hold;
  logic       PadSync;
  logic       PadLuma;
  logic       PadActive;
  logic       FrmFormat;
  logic [8:0] LineCount;

  modport master (
    output HSn, FSn, Format,
    input  Hold, PadSync, PadLuma, PadActive, FrmFormat, LineCount
  );

  modport slave (
    input  HSn, FSn, Format,
    output Hold, PadSync, PadLuma, PadActive, FrmFormat, LineCount
  );
endinterface

// File: rtl/pal_line_scheduler.sv
// PAL padding-line scheduler.
// Counts VDG lines from HSn/FSn and, at two programmed lines of a PAL frame,
// freezes the VDG for whole PAL line periods while emitting synthetic
// sync (PadSync) and luma-pad (PadLuma) strobes. NTSC frames pass through.
module pal_line_scheduler #(
  parameter int LINE_LEN = 284,
  parameter int SYNC_LEN = 21,
  parameter int TOP_LINE = 24,
  parameter int TOP_PAD  = 25,
  parameter int BOT_LINE = 216,
  parameter int BOT_PAD  = 25
) (
  input logic PALClock,
  input logic RESETn,
  pal_line_scheduler_if.slave bus
);

  localparam int CW   = $clog2(LINE_LEN + 1);
  localparam int PMAX = (TOP_PAD > BOT_PAD) ? TOP_PAD : BOT_PAD;
  localparam int PW   = $clog2(PMAX + 2);

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] BODY_LAST = CW'(LINE_LEN - SYNC_LEN - 1);
  localparam logic [8:0]    TOP_L     = 9'(TOP_LINE);
  localparam logic [8:0]    BOT_L     = 9'(BOT_LINE);
  localparam logic [PW-1:0] TOP_N     = PW'(TOP_PAD);
  localparam logic [PW-1:0] BOT_N     = PW'(BOT_PAD);

  typedef enum logic [1:0] {IDLE, PAD_SYNC, PAD_BODY} state_t;

  // two-flop synchronisers plus previous-value flops for fall detection
  logic hs_meta_q, hs_sync_q, hs_prev_q;
  logic fs_meta_q, fs_sync_q, fs_prev_q;
  logic fmt_meta_q, fmt_sync_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [8:0]    line_cnt_q, line_cnt_d;
  logic          frm_fmt_q, frm_fmt_d;
  logic          hold_q, hold_d;
  logic          psync_q, psync_d;
  logic          pluma_q, pluma_d;
  logic          pact_q, pact_d;

  logic       hs_fall, fs_fall;
  logic [8:0] line_inc;

  assign hs_fall  = hs_prev_q && !hs_sync_q;
  assign fs_fall  = fs_prev_q && !fs_sync_q;
  assign line_inc = (line_cnt_q == 9'd511) ? line_cnt_q : line_cnt_q + 9'd1;

  // Synchronise the asynchronous VDG inputs; idle-high reset avoids a fake fall
  always_ff @(posedge PALClock or negedge RESETn) begin
    if (!RESETn) begin
      hs_meta_q  <= 1'b1;
      hs_sync_q  <= 1'b1;
      hs_prev_q  <= 1'b1;
      fs_meta_q  <= 1'b1;
      fs_sync_q  <= 1'b1;
      fs_prev_q  <= 1'b1;
      fmt_meta_q <= 1'b1;
      fmt_sync_q <= 1'b1;
    end else begin
      hs_meta_q  <= bus.HSn;
      hs_sync_q  <= hs_meta_q;
      hs_prev_q  <= hs_sync_q;
      fs_meta_q  <= bus.FSn;
      fs_sync_q  <= fs_meta_q;
      fs_prev_q  <= fs_sync_q;
      fmt_meta_q <= bus.Format;
      fmt_sync_q <= fmt_meta_q;
    end
  end

  // Next state: FSn fall wins over everything, else line counting / padding
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    line_cnt_d = line_cnt_q;
    frm_fmt_d  = frm_fmt_q;
    if (fs_fall) begin
      line_cnt_d = 9'd0;
      frm_fmt_d  = fmt_sync_q;
      state_d    = IDLE;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_fall) begin
            line_cnt_d = line_inc;
            if (!frm_fmt_q && TOP_PAD > 0 && line_inc == TOP_L) begin
              rem_d   = TOP_N;
              state_d = PAD_SYNC;
              cnt_d   = '0;
            end else if (!frm_fmt_q && BOT_PAD > 0 && line_inc == BOT_L) begin
              rem_d   = BOT_N;
              state_d = PAD_SYNC;
              cnt_d   = '0;
            end
          end
        end
        PAD_SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_d = PAD_BODY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAD_BODY: begin
          if (cnt_q == BODY_LAST) begin
            cnt_d = '0;
            rem_d = rem_q - 1'b1;
            state_d = (rem_q == PW'(1)) ? IDLE : PAD_SYNC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // outputs come from the next state so they are registered alongside it
    hold_d  = (state_d != IDLE);
    psync_d = (state_d == PAD_SYNC);
    pluma_d = (state_d == PAD_BODY);
    pact_d  = hold_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge PALClock or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      line_cnt_q <= 9'd0;
      frm_fmt_q  <= 1'b1;
      hold_q     <= 1'b0;
      psync_q    <= 1'b0;
      pluma_q    <= 1'b0;
      pact_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      line_cnt_q <= line_cnt_d;
      frm_fmt_q  <= frm_fmt_d;
      hold_q     <= hold_d;
      psync_q    <= psync_d;
      pluma_q    <= pluma_d;
      pact_q     <= pact_d;
    end
  end

  assign bus.Hold      = hold_q;
  assign bus.PadSync   = psync_q;
  assign bus.PadLuma   = pluma_q;
  assign bus.PadActive = pact_q;
  assign bus.FrmFormat = frm_fmt_q;
  assign bus.LineCount = line_cnt_q;

endmodule

// File: tb/tb_pal_line_scheduler.sv
// Directed bench for pal_line_scheduler with small line/pad parameters.
module tb_pal_line_scheduler;
  localparam int LINE_LEN = 10;
  localparam int SYNC_LEN = 3;

  logic PALClock = 1'b0;
  logic RESETn;
  always #5 PALClock = ~PALClock;

  pal_line_scheduler_if bus();

  pal_line_scheduler #(
    .LINE_LEN(LINE_LEN), .SYNC_LEN(SYNC_LEN),
    .TOP_LINE(2), .TOP_PAD(2), .BOT_LINE(5), .BOT_PAD(1)
  ) dut (
    .PALClock(PALClock),
    .RESETn(RESETn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one-cycle low pulse on HSn; returns at the negedge after the sampling edge
  task automatic hs_fall();
    @(negedge PALClock) bus.HSn = 1'b0;
    @(negedge PALClock) bus.HSn = 1'b1;
  endtask

  // FSn pulse, returns once the fall has been processed
  task automatic fs_fall();
    @(negedge PALClock) bus.FSn = 1'b0;
    @(negedge PALClock) bus.FSn = 1'b1;
    repeat (2) @(negedge PALClock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PALClock);
  endtask

  // call right after the triggering hs_fall; checks the whole padded block
  task automatic pad_check(input string tag, input int lines);
    int c;
    logic eh, es;
    @(negedge PALClock);
    chk({tag, ".pre"}, bus.Hold, 1'b0);
    for (c = 0; c <= lines * LINE_LEN; c++) begin
      @(negedge PALClock);
      eh = (c < lines * LINE_LEN);
      es = eh && ((c % LINE_LEN) < SYNC_LEN);
      chk($sformatf("%s.hold.c%0d", tag, c), bus.Hold, eh);
      chk($sformatf("%s.sync.c%0d", tag, c), bus.PadSync, es);
      chk($sformatf("%s.luma.c%0d", tag, c), bus.PadLuma, eh && !es);
      chk($sformatf("%s.act.c%0d", tag, c), bus.PadActive, eh);
    end
  endtask

  // watch n cycles and report whether any pad strobe appeared
  task automatic quiet(input string tag, input int n);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge PALClock);
      if (bus.Hold || bus.PadSync || bus.PadLuma || bus.PadActive) bad = 1'b1;
    end
    chk(tag, bad, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESETn = 1'b0;
    bus.HSn = 1'b1;
    bus.FSn = 1'b1;
    bus.Format = 1'b1;
    idle(3);
    chk("rst.hold", bus.Hold, 1'b0);
    chk("rst.sync", bus.PadSync, 1'b0);
    chk("rst.luma", bus.PadLuma, 1'b0);
    chk("rst.act", bus.PadActive, 1'b0);
    chk("rst.fmt", bus.FrmFormat, 1'b1);
    chk("rst.lc", bus.LineCount, 9'd0);
    RESETn = 1'b1;
    idle(3);

    // PAL frame: top block of 2 lines at line 2, bottom block of 1 at line 5
    bus.Format = 1'b0;
    idle(3);
    fs_fall();
    chk("pal.fmt", bus.FrmFormat, 1'b0);
    chk("pal.lc0", bus.LineCount, 9'd0);
    hs_fall(); idle(2);
    chk("pal.lc1", bus.LineCount, 9'd1);
    hs_fall();
    pad_check("top", 2);
    chk("pal.lc2", bus.LineCount, 9'd2);
    hs_fall(); hs_fall(); idle(2);
    chk("pal.lc4", bus.LineCount, 9'd4);
    hs_fall();
    pad_check("bot", 1);
    hs_fall(); idle(2);
    chk("pal.lc6", bus.LineCount, 9'd6);

    // NTSC frame: counts only
    bus.Format = 1'b1;
    idle(3);
    fs_fall();
    chk("ntsc.fmt", bus.FrmFormat, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      hs_fall();
      quiet($sformatf("ntsc.quiet%0d", i), 12);
      chk($sformatf("ntsc.lc%0d", i), bus.LineCount, 9'(i));
    end

    // Format flips mid-frame: this frame pads, next does not
    bus.Format = 1'b0;
    idle(3);
    fs_fall();
    hs_fall();
    bus.Format = 1'b1;
    hs_fall();
    pad_check("midfmt", 2);
    idle(3);
    fs_fall();
    chk("midfmt.fmt", bus.FrmFormat, 1'b1);
    hs_fall(); hs_fall();
    quiet("midfmt.next", 15);
    chk("midfmt.lc", bus.LineCount, 9'd2);

    // FSn fall at padded cycle 5 aborts the block
    bus.Format = 1'b0;
    idle(3);
    fs_fall();
    hs_fall(); hs_fall();
    idle(2);
    idle(5);
    chk("abort.hold_c5", bus.Hold, 1'b1);
    bus.FSn = 1'b0;
    @(negedge PALClock) bus.FSn = 1'b1;
    @(negedge PALClock);
    chk("abort.hold_r1", bus.Hold, 1'b1);
    @(negedge PALClock);
    chk("abort.hold_r2", bus.Hold, 1'b0);
    chk("abort.act", bus.PadActive, 1'b0);
    chk("abort.lc", bus.LineCount, 9'd0);
    quiet("abort.quiet", 25);
    hs_fall(); idle(2);
    chk("abort.lc1", bus.LineCount, 9'd1);

    // HSn and FSn fall together: FSn wins, HSn not counted
    bus.Format = 1'b1;
    idle(3);
    fs_fall();
    hs_fall(); hs_fall(); hs_fall(); idle(2);
    chk("both.lc3", bus.LineCount, 9'd3);
    @(negedge PALClock) begin bus.HSn = 1'b0; bus.FSn = 1'b0; end
    @(negedge PALClock) begin bus.HSn = 1'b1; bus.FSn = 1'b1; end
    idle(2);
    chk("both.lc0", bus.LineCount, 9'd0);
    hs_fall(); idle(2);
    chk("both.lc1", bus.LineCount, 9'd1);

    // HSn glitches during PAD_BODY are ignored
    bus.Format = 1'b0;
    idle(3);
    fs_fall();
    hs_fall(); hs_fall();
    idle(6);
    hs_fall(); idle(3);
    chk("glitch.hold1", bus.Hold, 1'b1);
    chk("glitch.lc1", bus.LineCount, 9'd2);
    idle(6);
    hs_fall(); idle(2);
    chk("glitch.hold2", bus.Hold, 1'b1);
    chk("glitch.lc2", bus.LineCount, 9'd2);
    idle(10);
    chk("glitch.done", bus.Hold, 1'b0);
    chk("glitch.lc3", bus.LineCount, 9'd2);

    // Reset mid-PAD_SYNC clears outputs without a clock edge
    idle(3);
    fs_fall();
    hs_fall(); hs_fall();
    idle(3);
    chk("rstmid.sync", bus.PadSync, 1'b1);
    #2 RESETn = 1'b0;
    #1;
    chk("rstmid.hold", bus.Hold, 1'b0);
    chk("rstmid.psync", bus.PadSync, 1'b0);
    chk("rstmid.luma", bus.PadLuma, 1'b0);
    chk("rstmid.act", bus.PadActive, 1'b0);
    chk("rstmid.fmt", bus.FrmFormat, 1'b1);
    chk("rstmid.lc", bus.LineCount, 9'd0);
    @(negedge PALClock) RESETn = 1'b1;
    idle(3);
    hs_fall(); hs_fall();
    quiet("rstmid.quiet", 15);
    fs_fall();
    hs_fall(); hs_fall(); idle(2);
    chk("rstmid.repad", bus.Hold, 1'b1);
    idle(25);

    // LineCount saturates at 511
    bus.Format = 1'b1;
    idle(3);
    fs_fall();
    repeat (515) hs_fall();
    idle(2);
    chk("sat.lc", bus.LineCount, 9'd511);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
